// File: rtl/gsau_wb_queue.sv
// Pairs scoreboard tags with systolic-array output rows and offers them in order to writeback.
// Latency: a push is visible at the head one edge later. Backpressure: heads hold while wb_output_ready is low; full FIFOs drop pushes and set err_overflow.
// Optional GSAU_WB_STATS_EN adds a saturating writeback stall counter on stall_cycles.

module gsau_wb_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       drop
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          wr_en;

    assign full  = (count == (AW+1)'(DEPTH));
    // A full FIFO still accepts a push when its head leaves in the same cycle.
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;
    assign dout  = mem[rptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clr) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_en) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (wr_en && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !wr_en) begin
                count <= count - 1'b1;
            end
        end
    end
endmodule

module gsau_wb_queue #(
    parameter int DATA_W    = 512,
    parameter int TAG_W     = 8,
    parameter int TAG_DEPTH = 8,
    parameter int OUT_DEPTH = 4
) (
    input  logic                         CLK,
    input  logic                         nRST,
    input  logic                         flush,
    input  logic                         sb_nvalid,
    input  logic [TAG_W-1:0]             sb_nvdst,
    output logic                         sb_ready,
    input  logic                         sa_out_en,
    input  logic [DATA_W-1:0]            sa_array_output,
    output logic                         sa_fifo_has_space,
    input  logic                         wb_output_ready,
    output logic                         wb_valid,
    output logic [TAG_W-1:0]             wb_wbdst,
    output logic [DATA_W-1:0]            wb_data,
    output logic [$clog2(TAG_DEPTH):0]   tag_count,
    output logic [$clog2(OUT_DEPTH):0]   out_count,
    output logic                         err_overflow,
    output logic [31:0]                  stall_cycles
);
    logic pop;
    logic tag_full;
    logic out_full;
    logic tag_drop;
    logic out_drop;

    assign wb_valid          = (tag_count != '0) && (out_count != '0);
    assign pop               = wb_valid && wb_output_ready;
    assign sb_ready          = !tag_full;
    assign sa_fifo_has_space = !out_full;

    gsau_wb_fifo #(.W(TAG_W), .DEPTH(TAG_DEPTH)) u_tag_fifo (
        .clk   (CLK),
        .rst_n (nRST),
        .clr   (flush),
        .push  (sb_nvalid),
        .pop   (pop),
        .din   (sb_nvdst),
        .dout  (wb_wbdst),
        .count (tag_count),
        .full  (tag_full),
        .drop  (tag_drop)
    );

    gsau_wb_fifo #(.W(DATA_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk   (CLK),
        .rst_n (nRST),
        .clr   (flush),
        .push  (sa_out_en),
        .pop   (pop),
        .din   (sa_array_output),
        .dout  (wb_data),
        .count (out_count),
        .full  (out_full),
        .drop  (out_drop)
    );

    // Sticky until reset; flush deliberately leaves it alone.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            err_overflow <= 1'b0;
        end else if (tag_drop || out_drop) begin
            err_overflow <= 1'b1;
        end
    end

`ifdef GSAU_WB_STATS_EN
    logic [31:0] stall_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_q <= '0;
        end else if (flush) begin
            stall_q <= '0;
        end else if (wb_valid && !wb_output_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 32'd0;
`endif
endmodule

// File: tb/tb_gsau_wb_queue.sv
// Directed bench for gsau_wb_queue: pairing, stall hold, ordering, full/overflow, flush and reset.
module tb_gsau_wb_queue;
    localparam int DATA_W = 512;
    localparam int TAG_W  = 8;

    logic              CLK = 1'b0;
    logic              nRST;
    logic              flush;
    logic              sb_nvalid;
    logic [TAG_W-1:0]  sb_nvdst;
    logic              sb_ready;
    logic              sa_out_en;
    logic [DATA_W-1:0] sa_array_output;
    logic              sa_fifo_has_space;
    logic              wb_output_ready;
    logic              wb_valid;
    logic [TAG_W-1:0]  wb_wbdst;
    logic [DATA_W-1:0] wb_data;
    logic [3:0]        tag_count;
    logic [2:0]        out_count;
    logic              err_overflow;
    logic [31:0]       stall_cycles;

    int passed = 0;
    int total  = 0;

    logic [DATA_W-1:0] row_beef;
    logic [TAG_W-1:0]  held_tag;
    logic [DATA_W-1:0] held_data;

    gsau_wb_queue dut (
        .CLK               (CLK),
        .nRST              (nRST),
        .flush             (flush),
        .sb_nvalid         (sb_nvalid),
        .sb_nvdst          (sb_nvdst),
        .sb_ready          (sb_ready),
        .sa_out_en         (sa_out_en),
        .sa_array_output   (sa_array_output),
        .sa_fifo_has_space (sa_fifo_has_space),
        .wb_output_ready   (wb_output_ready),
        .wb_valid          (wb_valid),
        .wb_wbdst          (wb_wbdst),
        .wb_data           (wb_data),
        .tag_count         (tag_count),
        .out_count         (out_count),
        .err_overflow      (err_overflow),
        .stall_cycles      (stall_cycles)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        flush           = 1'b0;
        sb_nvalid       = 1'b0;
        sa_out_en       = 1'b0;
        wb_output_ready = 1'b0;
    endtask

    task automatic push_row(input logic [DATA_W-1:0] d);
        sa_out_en = 1'b1; sa_array_output = d;
        tick();
        sa_out_en = 1'b0;
    endtask

    task automatic push_tag(input logic [TAG_W-1:0] t);
        sb_nvalid = 1'b1; sb_nvdst = t;
        tick();
        sb_nvalid = 1'b0;
    endtask

    task automatic test_reset();
        nRST = 1'b0; idle(); sb_nvdst = '0; sa_array_output = '0;
        tick(); tick();
        total++; if (tag_count !== 4'd0) $display("FAIL reset_tag_count got %0d want 0", tag_count); else passed++;
        total++; if (out_count !== 3'd0) $display("FAIL reset_out_count got %0d want 0", out_count); else passed++;
        total++; if (wb_valid !== 1'b0) $display("FAIL reset_wb_valid got %b want 0", wb_valid); else passed++;
        total++; if (sb_ready !== 1'b1) $display("FAIL reset_sb_ready got %b want 1", sb_ready); else passed++;
        total++; if (sa_fifo_has_space !== 1'b1) $display("FAIL reset_has_space got %b want 1", sa_fifo_has_space); else passed++;
        total++; if (err_overflow !== 1'b0) $display("FAIL reset_err got %b want 0", err_overflow); else passed++;
        total++; if (stall_cycles !== 32'd0) $display("FAIL reset_stall got %0d want 0", stall_cycles); else passed++;
        nRST = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        row_beef = {16'hDEAD, 480'h0, 16'hBEEF};
        push_tag(8'h0A);
        total++; if (tag_count !== 4'd1) $display("FAIL basic_tag_count got %0d want 1", tag_count); else passed++;
        total++; if (wb_valid !== 1'b0) $display("FAIL basic_valid_tag_only got %b want 0", wb_valid); else passed++;
        push_row(row_beef);
        total++; if (wb_valid !== 1'b1) $display("FAIL basic_valid got %b want 1", wb_valid); else passed++;
        total++; if (wb_wbdst !== 8'h0A) $display("FAIL basic_wbdst got %h want 0a", wb_wbdst); else passed++;
        total++; if (wb_data !== row_beef) $display("FAIL basic_data got %h want %h", wb_data, row_beef); else passed++;
        wb_output_ready = 1'b1;
        tick();
        wb_output_ready = 1'b0;
        total++; if (wb_valid !== 1'b0) $display("FAIL basic_pop_valid got %b want 0", wb_valid); else passed++;
        total++; if ({tag_count, out_count} !== 7'd0) $display("FAIL basic_pop_counts got %0d/%0d want 0/0", tag_count, out_count); else passed++;
    endtask

    task automatic test_stall();
        sb_nvalid = 1'b1; sb_nvdst = 8'h11;
        sa_out_en = 1'b1; sa_array_output = DATA_W'(32'h1111_2222);
        tick();
        sb_nvalid = 1'b0; sa_out_en = 1'b0;
        held_tag = 8'h11; held_data = DATA_W'(32'h1111_2222);
        for (int i = 0; i < 3; i++) begin
            sb_nvdst = 8'hFF; sa_array_output = '1;
            tick();
            total++; if (wb_valid !== 1'b1) $display("FAIL stall_valid[%0d] got %b want 1", i, wb_valid); else passed++;
            total++; if (wb_wbdst !== held_tag || wb_data !== held_data)
                $display("FAIL stall_hold[%0d] got %h/%h want %h/%h", i, wb_wbdst, wb_data[31:0], held_tag, held_data[31:0]);
            else passed++;
        end
`ifdef GSAU_WB_STATS_EN
        total++; if (stall_cycles !== 32'd3) $display("FAIL stall_count got %0d want 3", stall_cycles); else passed++;
`else
        total++; if (stall_cycles !== 32'd0) $display("FAIL stall_count got %0d want 0", stall_cycles); else passed++;
`endif
        wb_output_ready = 1'b1;
        tick();
        wb_output_ready = 1'b0;
        total++; if (wb_valid !== 1'b0) $display("FAIL stall_pop got %b want 0", wb_valid); else passed++;
    endtask

    task automatic test_order();
        logic [TAG_W-1:0]  et;
        logic [DATA_W-1:0] ed;
        push_tag(8'h01); push_tag(8'h02); push_tag(8'h03);
        push_row(DATA_W'(8'hD1)); push_row(DATA_W'(8'hD2)); push_row(DATA_W'(8'hD3));
        total++; if (tag_count !== 4'd3 || out_count !== 3'd3) $display("FAIL order_counts got %0d/%0d want 3/3", tag_count, out_count); else passed++;
        wb_output_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            et = TAG_W'(k);
            ed = DATA_W'(8'hD0 + k);
            total++; if (wb_valid !== 1'b1 || wb_wbdst !== et || wb_data !== ed)
                $display("FAIL order_pair%0d got %b %h %h want 1 %h %h", k, wb_valid, wb_wbdst, wb_data[7:0], et, ed[7:0]);
            else passed++;
            tick();
        end
        wb_output_ready = 1'b0;
        total++; if (wb_valid !== 1'b0) $display("FAIL order_empty got %b want 0", wb_valid); else passed++;
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 4; i++) push_row(DATA_W'(8'hE0 + i));
        total++; if (sa_fifo_has_space !== 1'b0) $display("FAIL fullpop_space got %b want 0", sa_fifo_has_space); else passed++;
        push_tag(8'h44);
        total++; if (wb_valid !== 1'b1) $display("FAIL fullpop_valid got %b want 1", wb_valid); else passed++;
        wb_output_ready = 1'b1; sa_out_en = 1'b1; sa_array_output = DATA_W'(8'hE4);
        tick();
        idle();
        total++; if (out_count !== 3'd4) $display("FAIL fullpop_out_count got %0d want 4", out_count); else passed++;
        total++; if (err_overflow !== 1'b0) $display("FAIL fullpop_err got %b want 0", err_overflow); else passed++;
        total++; if (tag_count !== 4'd0) $display("FAIL fullpop_tag_count got %0d want 0", tag_count); else passed++;
        total++; if (wb_data !== DATA_W'(8'hE1)) $display("FAIL fullpop_head got %h want e1", wb_data[7:0]); else passed++;
    endtask

    task automatic test_overflow();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total++; if (out_count !== 3'd0) $display("FAIL ovf_flushed got %0d want 0", out_count); else passed++;
        for (int i = 0; i < 4; i++) push_row(DATA_W'(8'hF0 + i));
        total++; if (sa_fifo_has_space !== 1'b0 || out_count !== 3'd4)
            $display("FAIL ovf_full got space=%b count=%0d want 0/4", sa_fifo_has_space, out_count);
        else passed++;
        total++; if (err_overflow !== 1'b0) $display("FAIL ovf_err_early got %b want 0", err_overflow); else passed++;
        push_row(DATA_W'(8'hF4));
        total++; if (err_overflow !== 1'b1) $display("FAIL ovf_err got %b want 1", err_overflow); else passed++;
        total++; if (out_count !== 3'd4) $display("FAIL ovf_count got %0d want 4", out_count); else passed++;
        total++; if (wb_data !== DATA_W'(8'hF0)) $display("FAIL ovf_head got %h want f0", wb_data[7:0]); else passed++;
    endtask

    task automatic test_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sb_nvalid = 1'b1; sb_nvdst = TAG_W'(8'h21 + i);
            sa_out_en = 1'b1; sa_array_output = DATA_W'(8'h21 + i);
            tick();
        end
        idle();
        total++; if (tag_count !== 4'd2 || out_count !== 3'd2 || wb_valid !== 1'b1)
            $display("FAIL flush_setup got %0d/%0d v=%b want 2/2 v=1", tag_count, out_count, wb_valid);
        else passed++;
        flush = 1'b1; sb_nvalid = 1'b1; sa_out_en = 1'b1; wb_output_ready = 1'b1;
        tick();
        idle();
        total++; if (tag_count !== 4'd0 || out_count !== 3'd0) $display("FAIL flush_counts got %0d/%0d want 0/0", tag_count, out_count); else passed++;
        total++; if (wb_valid !== 1'b0) $display("FAIL flush_valid got %b want 0", wb_valid); else passed++;
        total++; if (err_overflow !== 1'b1) $display("FAIL flush_err_kept got %b want 1", err_overflow); else passed++;
        total++; if (stall_cycles !== 32'd0) $display("FAIL flush_stall got %0d want 0", stall_cycles); else passed++;
        sb_nvalid = 1'b1; sb_nvdst = 8'h31; sa_out_en = 1'b1; sa_array_output = DATA_W'(8'h31);
        tick();
        idle();
        total++; if (wb_valid !== 1'b1 || wb_wbdst !== 8'h31 || wb_data !== DATA_W'(8'h31))
            $display("FAIL flush_after got %b %h %h want 1 31 31", wb_valid, wb_wbdst, wb_data[7:0]);
        else passed++;
    endtask

    task automatic test_reset_mid();
        sb_nvalid = 1'b1; sb_nvdst = 8'h32; sa_out_en = 1'b1; sa_array_output = DATA_W'(8'h32);
        tick();
        idle();
        tick();
        #2;
        nRST = 1'b0;
        #1;
        total++; if (tag_count !== 4'd0 || out_count !== 3'd0) $display("FAIL rst_mid_counts got %0d/%0d want 0/0", tag_count, out_count); else passed++;
        total++; if (wb_valid !== 1'b0 || sb_ready !== 1'b1 || sa_fifo_has_space !== 1'b1)
            $display("FAIL rst_mid_flags got v=%b r=%b s=%b want 0 1 1", wb_valid, sb_ready, sa_fifo_has_space);
        else passed++;
        total++; if (err_overflow !== 1'b0 || stall_cycles !== 32'd0)
            $display("FAIL rst_mid_err_stall got %b/%0d want 0/0", err_overflow, stall_cycles);
        else passed++;
        tick();
        nRST = 1'b1;
        tick();
        total++; if (wb_valid !== 1'b0 || tag_count !== 4'd0) $display("FAIL rst_release got v=%b t=%0d want 0/0", wb_valid, tag_count); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_order();
        test_full_push_pop();
        test_overflow();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/gsau_wb_queue.md
GSAU_WB_QUEUE -- requirements
Module: gsau_wb_queue

Interface
REQ-001 The block SHALL have parameter DATA_W, default 512, meaning the systolic-array output row width in bits.
REQ-002 The block SHALL have parameter TAG_W, default 8, meaning the destination-register tag width.
REQ-003 The block SHALL have parameter TAG_DEPTH, default 8, meaning the tag FIFO entry count (power of two, >=2).
REQ-004 The block SHALL have parameter OUT_DEPTH, default 4, meaning the output data FIFO entry count (power of two, >=2).
REQ-005 The block SHALL have port CLK  input  1  clock; all state SHALL update on the rising edge.
REQ-006 The block SHALL have port nRST  input  1  reset; asynchronous, active-low.
REQ-007 The block SHALL have port flush  input  1  synchronous clear of both FIFOs.
REQ-008 The block SHALL have port sb_nvalid  input  1  dispatch of a tag from the scoreboard.
REQ-009 The block SHALL have port sb_nvdst  input  TAG_W  destination tag.
REQ-010 The block SHALL have port sb_ready  output  1  high when the tag FIFO is not full.
REQ-011 The block SHALL have port sa_out_en  input  1  systolic-array output row valid.
REQ-012 The block SHALL have port sa_array_output  input  DATA_W  output row data.
REQ-013 The block SHALL have port sa_fifo_has_space  output  1  high when the data FIFO is not full.
REQ-014 The block SHALL have port wb_output_ready  input  1  writeback accepts data.
REQ-015 The block SHALL have port wb_valid  output  1  a paired tag+data is offered.
REQ-016 The block SHALL have port wb_wbdst  output  TAG_W  tag at the head of the tag FIFO.
REQ-017 The block SHALL have port wb_data  output  DATA_W  data at the head of the data FIFO.
REQ-018 The block SHALL have port tag_count  output  $clog2(TAG_DEPTH)+1  tag FIFO occupancy.
REQ-019 The block SHALL have port out_count  output  $clog2(OUT_DEPTH)+1  data FIFO occupancy.
REQ-020 The block SHALL have port err_overflow  output  1  sticky flag for a dropped push.
REQ-021 The block SHALL have port stall_cycles  output  32  writeback stall counter.

Function
REQ-022 On sb_nvalid, the block SHALL write sb_nvdst into the tag FIFO when the FIFO is not full or a pop occurs in the same cycle.
REQ-023 On sa_out_en, the block SHALL write sa_array_output into the data FIFO under the same full/pop rule.
REQ-024 A push refused by REQ-022 or REQ-023 SHALL be discarded and SHALL set err_overflow; the flag SHALL remain set until reset.
REQ-025 wb_valid SHALL equal (tag_count!=0 && out_count!=0), driven combinationally from registered state only.
REQ-026 When wb_valid && wb_output_ready, the block SHALL pop both FIFO heads together (pop) in that cycle.
REQ-027 Pairing SHALL be strictly in order: the k-th dispatched tag SHALL pair with the k-th output row.
REQ-028 Latency: a push at edge N SHALL be visible at the head (wb_valid/wb_wbdst/wb_data) after edge N when its partner is present.
REQ-029 Counts SHALL increment on push only, decrement on pop only, and stay unchanged on simultaneous push+pop.
REQ-030 Read/write pointers SHALL wrap modulo depth.
REQ-031 While wb_valid && !wb_output_ready, wb_wbdst and wb_data SHALL hold stable.
REQ-032 flush SHALL zero both counts and pointers at the next edge, override any same-cycle push or pop, and leave err_overflow unchanged.
REQ-033 sb_ready SHALL equal (tag_count!=TAG_DEPTH); sa_fifo_has_space SHALL equal (out_count!=OUT_DEPTH).

Reset
REQ-034 While nRST is low, the block SHALL hold tag_count=0, out_count=0, pointers=0, err_overflow=0, stall_cycles=0, wb_valid=0, sb_ready=1 and sa_fifo_has_space=1.
REQ-035 Asserting reset mid-operation SHALL discard all queued entries immediately; FIFO storage contents need not reset.

Configuration
REQ-036 With GSAU_WB_STATS_EN defined, stall_cycles SHALL increment by 1 each cycle with wb_valid && !wb_output_ready, saturate at 32'hFFFFFFFF, and clear on flush.
REQ-037 Without GSAU_WB_STATS_EN, stall_cycles SHALL be constant 0 and no counter register SHALL be present.

Verification
REQ-038 The bench SHALL check basic pairing: after reset, tag 8'h0A is dispatched, then row 512'hDEAD...BEEF -> wb_valid=1 the next cycle with wbdst=0A and the data, popped with ready=1.
REQ-039 The bench SHALL check stall hold: a pair is offered with ready=0 for 3 cycles -> wb_valid=1, outputs stable, and stall_cycles=3 (STATS_EN); ready=1 then pops it.
REQ-040 The bench SHALL check ordering: tags 01,02,03 are dispatched before any rows, then three rows D1,D2,D3 -> pops in order (01,D1),(02,D2),(03,D3).
REQ-041 The bench SHALL check full and overflow: 4 rows pushed with no tags -> sa_fifo_has_space=0; a 5th row -> dropped, err_overflow=1, out_count=4.
REQ-042 The bench SHALL check full push+pop: a full data FIFO with ready=1 and a pending tag, plus a same-cycle sa_out_en -> out_count stays 4 and err_overflow stays 0.
REQ-043 The bench SHALL check flush and reset: flush with 2 pairs queued -> counts=0 and wb_valid=0 next cycle; nRST is pulsed mid-stream -> all outputs return to their reset values asynchronously.
